// File: rtl/cr_huf_comp_sa_axi4s_mstr_mc.sv
// Round-robin drain of N_CH show-ahead sources onto one AXI4-stream through a 2-entry output buffer.
// Optional backpressure counter enabled by defining CR_HUF_SA_MSTR_STALL_CNT_EN.
module cr_huf_comp_sa_axi4s_mstr_mc #(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 64,
    parameter int USER_W     = 8,
    parameter bit FRAME_LOCK = 1'b1,
    parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        in_empty,
    input  logic [N_CH-1:0]        in_aempty,
    input  logic [N_CH*DATA_W-1:0] in_tdata,
    input  logic [N_CH*USER_W-1:0] in_tuser,
    input  logic [N_CH-1:0]        in_tlast,
    output logic [N_CH-1:0]        in_rd,
    input  logic                   ob_tready,
    output logic                   ob_tvalid,
    output logic [DATA_W-1:0]      ob_tdata,
    output logic [USER_W-1:0]      ob_tuser,
    output logic                   ob_tlast,
    output logic [CH_W-1:0]        ob_tid,
    input  logic                   stall_clr,
    output logic [31:0]            stall_cnt
);
    localparam int ENT_W = CH_W + 1 + USER_W + DATA_W;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [CH_W-1:0]  ptr;
    logic [CH_W-1:0]  gnt;
    logic [CH_W-1:0]  cand;
    logic             gnt_vld;
    logic             pop;
    logic             drain;
    logic [1:0]       count;
    logic [ENT_W-1:0] ent0, ent1, ent_new;
    logic             unused;

    assign unused = ^{in_aempty, stall_clr};

    // While locked the pointer already holds the frame's channel, so no separate lock register.
    always_comb begin
        gnt     = ptr;
        gnt_vld = 1'b0;
        cand    = ptr;
        if (state == LOCKED) begin
            gnt_vld = !in_empty[ptr];
        end else begin
            for (int i = 1; i <= N_CH; i++) begin
                cand = CH_W'((int'(ptr) + i) % N_CH);
                if (!gnt_vld && !in_empty[cand]) begin
                    gnt     = cand;
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    assign drain = ob_tvalid && ob_tready;
    assign pop   = gnt_vld && (count != 2'd2);

    always_comb begin
        in_rd = '0;
        if (pop && rst_n) in_rd[gnt] = 1'b1;
    end

    assign ent_new = {gnt, in_tlast[gnt], in_tuser[gnt*USER_W +: USER_W], in_tdata[gnt*DATA_W +: DATA_W]};

    always_comb begin
        state_nxt = state;
        if (FRAME_LOCK && pop) state_nxt = in_tlast[gnt] ? IDLE : LOCKED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (pop) ptr <= gnt;
        end
    end

    // ent0 is always the head; ent1 only holds data when count==2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (pop) begin
                        ent0  <= ent_new;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && drain) begin
                        ent0 <= ent_new;
                    end else if (pop) begin
                        ent1  <= ent_new;
                        count <= 2'd2;
                    end else if (drain) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (drain) begin
                        ent0  <= ent1;
                        count <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign ob_tvalid = (count != 2'd0);
    assign {ob_tid, ob_tlast, ob_tuser, ob_tdata} = ent0;

`ifdef CR_HUF_SA_MSTR_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 32'd0;
        end else if (stall_clr) begin
            stall_q <= 32'd0;
        end else if (ob_tvalid && !ob_tready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
